// File: rtl/sumcheck_fj_accum.sv
// Field definitions, the shared modular adder and the sumcheck fj accumulator.
//
// field_arith_defs : field width and prime (p = 2^61 - 1).
// field_adder      : one-cycle modular adder with an en/ready handshake.
//     clk, rstb : clock, async active-low reset
//     en        : sample a/b this cycle
//     a, b      : operands, both already reduced (< p)
//     ready     : pulses high the cycle after en, when c is valid
//     c         : (a + b) mod p, registered
// sumcheck_fj_accum : sums per-gate fj[0..2] values into sum[0..2] using a
//                     single shared field_adder, one term at a time.
//     clk, rstb   : clock, async active-low reset
//     en          : start one pass (sampled only in ST_IDLE)
//     restart     : with en, clear sums before the pass
//     fj_in       : NGATES x 3 field elements, gate g term k at (g*3+k)*F_NBITS
//     ready       : low while a pass is requested or in progress
//     ready_pulse : one-cycle pulse when a pass completes
//     sum         : sum[k] at k*F_NBITS, registered

package field_arith_defs;
    localparam int unsigned F_NBITS = 61;
    localparam logic [F_NBITS-1:0] PRIME = 61'h1FFF_FFFF_FFFF_FFFF;
endpackage

module field_adder
    import field_arith_defs::*;
(
    input  logic               clk,
    input  logic               rstb,
    input  logic               en,
    input  logic [F_NBITS-1:0] a,
    input  logic [F_NBITS-1:0] b,
    output logic               ready,
    output logic [F_NBITS-1:0] c
);
    logic [F_NBITS:0] raw_sum;
    logic [F_NBITS:0] red_sum;

    // Operands are < p, so a single conditional subtraction fully reduces.
    assign raw_sum = {1'b0, a} + {1'b0, b};
    assign red_sum = raw_sum - {1'b0, PRIME};

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ready <= 1'b0;
            c     <= '0;
        end else begin
            ready <= en;
            if (en) begin
                c <= (raw_sum >= {1'b0, PRIME}) ? red_sum[F_NBITS-1:0]
                                                : raw_sum[F_NBITS-1:0];
            end
        end
    end
endmodule

module sumcheck_fj_accum
    import field_arith_defs::*;
#(
    parameter int unsigned NGATES = 4
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          en,
    input  logic                          restart,
    input  logic [NGATES*3*F_NBITS-1:0]   fj_in,
    output logic                          ready,
    output logic                          ready_pulse,
    output logic [3*F_NBITS-1:0]          sum
);
    localparam int unsigned GW = (NGATES > 1) ? $clog2(NGATES) : 1;
    localparam logic [GW-1:0] G_LAST = GW'(NGATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state;
    logic [GW-1:0]      g;
    logic [1:0]         k;
    logic               add_en;
    logic               add_ready;
    logic [F_NBITS-1:0] add_a;
    logic [F_NBITS-1:0] add_b;
    logic [F_NBITS-1:0] add_c;
    logic [F_NBITS-1:0] sum_q [0:2];

    // Operand selection: current running sum and the (g,k) input term.
    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int j = 0; j < 3; j++) begin
            if (k == 2'(j)) add_a = sum_q[j];
        end
        for (int i = 0; i < int'(NGATES); i++) begin
            for (int j = 0; j < 3; j++) begin
                if (g == GW'(i) && k == 2'(j)) begin
                    add_b = fj_in[(i*3+j)*F_NBITS +: F_NBITS];
                end
            end
        end
    end

    field_adder u_add (
        .clk   (clk),
        .rstb  (rstb),
        .en    (add_en),
        .a     (add_a),
        .b     (add_b),
        .ready (add_ready),
        .c     (add_c)
    );

    // Pass sequencer: one addition in flight at a time, k fastest then g.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state  <= ST_IDLE;
            g      <= '0;
            k      <= '0;
            add_en <= 1'b0;
            for (int j = 0; j < 3; j++) sum_q[j] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    add_en <= 1'b0;
                    if (en) begin
                        g <= '0;
                        k <= '0;
                        if (restart) begin
                            state <= ST_CLR;
                        end else begin
                            state  <= ST_ADD;
                            add_en <= 1'b1;
                        end
                    end
                end
                ST_CLR: begin
                    for (int j = 0; j < 3; j++) sum_q[j] <= '0;
                    g      <= '0;
                    k      <= '0;
                    add_en <= 1'b1;
                    state  <= ST_ADD;
                end
                ST_ADD: begin
                    add_en <= 1'b0;
                    if (add_ready) begin
                        sum_q[k] <= add_c;
                        if (k == 2'd2) begin
                            k <= '0;
                            if (g == G_LAST) begin
                                state <= ST_DONE;
                            end else begin
                                g      <= g + GW'(1);
                                add_en <= 1'b1;
                            end
                        end else begin
                            k      <= k + 2'd1;
                            add_en <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    add_en <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    add_en <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // ready also drops in the very cycle en is accepted in ST_IDLE.
    assign ready       = !(((state == ST_IDLE) && en) || (state == ST_CLR) || (state == ST_ADD));
    assign ready_pulse = (state == ST_DONE);
    assign sum         = {sum_q[2], sum_q[1], sum_q[0]};
endmodule

// File: tb/tb_sumcheck_fj_accum.sv
// Scoreboard bench for sumcheck_fj_accum: three instances (NGATES = 4, 2, 1),
// expected sums queued per pass and checked by monitors on ready_pulse.
module tb_sumcheck_fj_accum;
    import field_arith_defs::*;

    localparam int unsigned F = F_NBITS;
    typedef logic [3*F-1:0] sum_t;

    logic           clk = 1'b0;
    logic           rstb;
    logic           restart;
    logic           en4, en2, en1;
    logic [4*3*F-1:0] fj4;
    logic [2*3*F-1:0] fj2;
    logic [1*3*F-1:0] fj1;
    logic           ready4, ready2, ready1;
    logic           rp4, rp2, rp1;
    sum_t           sum4, sum2, sum1;

    sumcheck_fj_accum #(.NGATES(4)) u4 (.clk(clk), .rstb(rstb), .en(en4), .restart(restart),
        .fj_in(fj4), .ready(ready4), .ready_pulse(rp4), .sum(sum4));
    sumcheck_fj_accum #(.NGATES(2)) u2 (.clk(clk), .rstb(rstb), .en(en2), .restart(restart),
        .fj_in(fj2), .ready(ready2), .ready_pulse(rp2), .sum(sum2));
    sumcheck_fj_accum #(.NGATES(1)) u1 (.clk(clk), .rstb(rstb), .en(en1), .restart(restart),
        .fj_in(fj1), .ready(ready1), .ready_pulse(rp1), .sum(sum1));

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    sum_t q4[$];
    sum_t q2[$];
    sum_t q1[$];
    int   adds4 = 0, adds2 = 0, adds1 = 0;

    always @(posedge clk) begin
        if (u4.add_en === 1'b1) adds4++;
        if (u2.add_en === 1'b1) adds2++;
        if (u1.add_en === 1'b1) adds1++;
    end

    function automatic sum_t mk(input longint unsigned s0, input longint unsigned s1,
                                input longint unsigned s2);
        return {F'(s2), F'(s1), F'(s0)};
    endfunction

    task automatic chk(input string nm, input sum_t act, input sum_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitors: every completion must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rstb === 1'b1 && rp4 === 1'b1) begin
            if (q4.size() == 0) begin
                checks++; failures++;
                $display("FAIL u4_unexpected_pulse: got sum %h expected no pulse", sum4);
            end else chk("u4_sum", sum4, q4.pop_front());
        end
        if (rstb === 1'b1 && rp2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++; failures++;
                $display("FAIL u2_unexpected_pulse: got sum %h expected no pulse", sum2);
            end else chk("u2_sum", sum2, q2.pop_front());
        end
        if (rstb === 1'b1 && rp1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL u1_unexpected_pulse: got sum %h expected no pulse", sum1);
            end else chk("u1_sum", sum1, q1.pop_front());
        end
    end

    function automatic logic get_ready(input int sel);
        case (sel)
            4:       return ready4;
            2:       return ready2;
            default: return ready1;
        endcase
    endfunction

    function automatic logic get_pulse(input int sel);
        case (sel)
            4:       return rp4;
            2:       return rp2;
            default: return rp1;
        endcase
    endfunction

    function automatic int get_adds(input int sel);
        case (sel)
            4:       return adds4;
            2:       return adds2;
            default: return adds1;
        endcase
    endfunction

    task automatic set_en(input int sel, input logic v);
        case (sel)
            4:       en4 = v;
            2:       en2 = v;
            default: en1 = v;
        endcase
    endtask

    // One pass on instance sel; optionally re-pulses en while busy.
    task automatic run_pass(input int sel, input bit rs, input bit noisy, input int n);
        int a0, low, pulses, cyc;
        bit done;
        @(negedge clk);
        a0 = get_adds(sel);
        set_en(sel, 1'b1);
        restart = rs;
        #1;
        low = 0; pulses = 0; cyc = 0; done = 1'b0;
        if (!get_ready(sel)) low++;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (get_pulse(sel)) pulses++;
            if (get_ready(sel)) done = 1'b1;
            else low++;
            set_en(sel, (noisy && !done && (cyc % 2 == 1)) ? 1'b1 : 1'b0);
        end
        restart = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL pass_timeout_u%0d: got no completion expected ready within 1000 cycles", sel);
        end
        chk($sformatf("u%0d_adds", sel), sum_t'(get_adds(sel) - a0), sum_t'(3 * n));
        repeat (2) begin
            @(negedge clk);
            if (get_pulse(sel)) pulses++;
        end
        chk($sformatf("u%0d_ready_low_cycles", sel), sum_t'(low), sum_t'(1 + int'(rs) + 6 * n));
        chk($sformatf("u%0d_pulse_count", sel), sum_t'(pulses), sum_t'(1));
    endtask

    initial begin
        int a0, cyc;
        rstb = 1'b1; restart = 1'b0;
        en4 = 1'b0; en2 = 1'b0; en1 = 1'b0;
        fj4 = '0; fj2 = '0; fj1 = '0;
        #2 rstb = 1'b0;
        #1;
        chk("reset_sum4", sum4, '0);
        chk("reset_sum2", sum2, '0);
        chk("reset_sum1", sum1, '0);
        chk("reset_ready_pulse", sum_t'({ready4, ready2, ready1, rp4, rp2, rp1}), sum_t'(6'b111000));
        repeat (3) @(negedge clk);
        rstb = 1'b1;

        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 3; k++)
                fj4[(g*3+k)*F +: F] = F'(10 * g + k);

        q4.push_back(mk(60, 64, 68));
        run_pass(4, 1'b1, 1'b0, 4);
        q4.push_back(mk(120, 128, 136));
        run_pass(4, 1'b0, 1'b0, 4);
        q4.push_back(mk(60, 64, 68));
        run_pass(4, 1'b1, 1'b0, 4);

        // Modular wrap: (p-1) + 2 = 1.
        for (int k = 0; k < 3; k++) begin
            fj2[(0*3+k)*F +: F] = PRIME - F'(1);
            fj2[(1*3+k)*F +: F] = F'(2);
        end
        q2.push_back(mk(1, 1, 1));
        run_pass(2, 1'b1, 1'b0, 2);

        // en hammered while busy: still exactly one pass.
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 3; k++)
                fj4[(g*3+k)*F +: F] = F'(g + k + 1);
        q4.push_back(mk(10, 14, 18));
        run_pass(4, 1'b1, 1'b1, 4);
        // restart alone in idle does nothing.
        restart = 1'b1;
        repeat (10) @(negedge clk);
        restart = 1'b0;
        chk("idle_hold_sum4", sum4, mk(10, 14, 18));
        chk("idle_ready4", sum_t'(ready4), sum_t'(1));

        fj1 = {F'(7), F'(6), F'(5)};
        q1.push_back(mk(5, 6, 7));
        run_pass(1, 1'b1, 1'b0, 1);

        // Abort a pass with reset after 5 additions.
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 3; k++)
                fj4[(g*3+k)*F +: F] = F'(10 * g + k);
        @(negedge clk);
        a0 = adds4;
        en4 = 1'b1; restart = 1'b1;
        @(negedge clk);
        en4 = 1'b0; restart = 1'b0;
        cyc = 0;
        while (adds4 - a0 < 5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_adds_reached", sum_t'(adds4 - a0), sum_t'(5));
        #2 rstb = 1'b0;
        #1;
        chk("abort_sum4", sum4, '0);
        chk("abort_ready4_pulse", sum_t'({ready4, rp4}), sum_t'(2'b10));
        chk("abort_sum1", sum1, '0);
        @(negedge clk);
        rstb = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_sum4_after", sum4, '0);
        q4.push_back(mk(60, 64, 68));
        run_pass(4, 1'b1, 1'b0, 4);

        // First pass after reset without restart: sums already zero.
        q1.push_back(mk(5, 6, 7));
        run_pass(1, 1'b0, 1'b0, 1);

        repeat (4) @(negedge clk);
        chk("queues_drained", sum_t'(q4.size() + q2.size() + q1.size()), sum_t'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
